// File: rtl/gaplus_rom_loader.sv
// rtl/gaplus_rom_loader.sv - HPS ioctl ROM download into the DLROM write port, CPU reset hold until verified.
// Optional running checksum of written bytes is built when ROMLOAD_CSUM_EN is defined.
module gaplus_rom_loader #(
  parameter logic [7:0]  ROM_INDEX = 8'h00,
  parameter logic [17:0] ROM_SIZE  = 18'h20800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        ROMCL,
  output logic [17:0] ROMAD,
  output logic [7:0]  ROMDT,
  output logic        ROMEN,
  output logic        cpu_rst,
  output logic        load_done,
  output logic        load_err,
  output logic [17:0] byte_cnt,
  output logic [15:0] csum
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE, S_ERR} state_t;

  state_t      state, state_nx;
  logic        sel, sel_q, start;
  logic        strobe, push_req, addr_ok, full, push, drop;
  logic        drain_active, pop, flush_idle, load_enter;
  logic        phase_gap, sticky_err;
  logic [25:0] fifo_mem [0:3];
  logic [25:0] head;
  logic [1:0]  wr_ptr, rd_ptr;
  logic [2:0]  fifo_cnt;

  assign ROMCL = clk;

  assign sel          = ioctl_download && (ioctl_index == ROM_INDEX);
  assign start        = sel && !sel_q;
  assign strobe       = ioctl_wr && sel;
  assign push_req     = (state == S_LOAD) && strobe;
  assign addr_ok      = ioctl_addr < {7'd0, ROM_SIZE};
  assign full         = (fifo_cnt == 3'd4);
  assign push         = push_req && addr_ok && !full;
  assign drop         = push_req && !push;
  assign drain_active = (state == S_LOAD) || (state == S_FLUSH);
  assign pop          = drain_active && !phase_gap && (fifo_cnt != 3'd0);
  assign flush_idle   = (fifo_cnt == 3'd0) && phase_gap;
  assign head         = fifo_mem[rd_ptr];
  assign ioctl_wait   = (fifo_cnt >= 3'd3);
  assign load_enter   = (state != S_LOAD) && (state_nx == S_LOAD);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (start) state_nx = S_LOAD;
      S_LOAD:                if (!ioctl_download) state_nx = S_FLUSH;
      S_FLUSH: begin
        // The drain is finished only once the last write pulse has completed (GAP with empty FIFO).
        if (flush_idle)
          state_nx = ((byte_cnt == ROM_SIZE) && !sticky_err) ? S_DONE : S_ERR;
      end
      default:               state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {ioctl_addr[17:0], ioctl_dout};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      sel_q      <= 1'b0;
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      fifo_cnt   <= 3'd0;
      phase_gap  <= 1'b0;
      sticky_err <= 1'b0;
      ROMAD      <= 18'd0;
      ROMDT      <= 8'd0;
      ROMEN      <= 1'b0;
      cpu_rst    <= 1'b1;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      byte_cnt   <= 18'd0;
    end else begin
      state <= state_nx;
      sel_q <= sel;
      if (load_enter) begin
        wr_ptr     <= 2'd0;
        rd_ptr     <= 2'd0;
        fifo_cnt   <= 3'd0;
        phase_gap  <= 1'b0;
        sticky_err <= 1'b0;
        ROMEN      <= 1'b0;
        cpu_rst    <= 1'b1;
        load_done  <= 1'b0;
        load_err   <= 1'b0;
        byte_cnt   <= 18'd0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 2'd1;
        if (pop)  rd_ptr <= rd_ptr + 2'd1;
        case ({push, pop})
          2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
          2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
          default: fifo_cnt <= fifo_cnt;
        endcase
        if (drop) sticky_err <= 1'b1;

        if (drain_active) begin
          if (phase_gap) begin
            ROMEN     <= 1'b0;
            phase_gap <= 1'b0;
          end else if (pop) begin
            ROMAD     <= head[25:8];
            ROMDT     <= head[7:0];
            ROMEN     <= 1'b1;
            phase_gap <= 1'b1;
            if (byte_cnt != 18'h3FFFF) byte_cnt <= byte_cnt + 18'd1;
          end else if (state == S_FLUSH) begin
            // Empty FIFO in FLUSH: step to GAP so the exit test can fire.
            phase_gap <= 1'b1;
          end
        end else begin
          ROMEN <= 1'b0;
        end

        if (state == S_FLUSH && state_nx == S_DONE) begin
          load_done <= 1'b1;
          cpu_rst   <= 1'b0;
        end
        if (state == S_FLUSH && state_nx == S_ERR) load_err <= 1'b1;
      end
    end
  end

`ifdef ROMLOAD_CSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          csum <= 16'h0000;
    else if (load_enter) csum <= 16'h0000;
    else if (pop)        csum <= csum + {8'd0, head[7:0]};
  end
`else
  assign csum = 16'h0000;
`endif

endmodule
